// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Holds a 4-entry digit/blank register file and cycles through the digits,
// one slot of DIV cycles each: BLANK guard cycles with all anodes dark
// (lets the segment lines settle between digits), then the lit portion.
// All outputs are registered from next-state values, so in any cycle they
// describe the state the FSM is in during that cycle.
module seg_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       wr_blank,
  output logic [3:0] digit_code,
  output logic [3:0] an,
  output logic       frame_tick,
  output logic [1:0] dbg_state
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_GUARD = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(BLANK - 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][3:0] digit_q, digit_d;
  logic [3:0]      blank_q, blank_d;
  logic [3:0]      an_q, an_d;
  logic [3:0]      code_q, code_d;
  logic            tick_q, tick_d;

  // Register file write port; accepted in every FSM state.
  always_comb begin
    digit_d = digit_q;
    blank_d = blank_q;
    if (wr_en) begin
      digit_d[wr_addr] = wr_data;
      blank_d[wr_addr] = wr_blank;
    end
  end

  // Scan FSM: slot counter and digit index advance; en low forces OFF.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
        ST_GUARD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GUARD_LAST) state_d = ST_ON;
        end
        ST_ON: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_GUARD;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end
  end

  // Output decode from next-state values so outputs line up with the state.
  always_comb begin
    an_d = 4'b1111;
    if (state_d == ST_ON && !blank_d[idx_d]) an_d = ~(4'b0001 << idx_d);
    code_d = digit_d[idx_d];
    tick_d = en && (state_q == ST_ON) && (cnt_q == CNT_LAST) && (idx_q == 2'd3);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      digit_q <= '0;
      blank_q <= 4'b1111;
      an_q    <= 4'b1111;
      code_q  <= 4'h0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      an_q    <= an_d;
      code_q  <= code_d;
      tick_q  <= tick_d;
    end
  end

  assign digit_code = code_q;
  assign an         = an_q;
  assign frame_tick = tick_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIV=8, BLANK=2 (32-cycle frame).
// Handshake note: the write port is a plain strobe, no ready; wr_en high
// at a rising edge commits the write on that edge.
module tb_seg_scan_ctrl;

  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_blank;
  logic [3:0] digit_code;
  logic [3:0] an;
  logic       frame_tick;
  logic [1:0] dbg_state;

  int n_checks;
  int n_fails;
  int k;

  logic [3:0] mdig [4];
  logic       mblk [4];

  seg_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_blank   (wr_blank),
    .digit_code (digit_code),
    .an         (an),
    .frame_tick (frame_tick),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fails++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
    end
  endtask

  // Expected outputs for cycle k of a scan started from GUARD idx0 cnt0.
  task automatic chk_cycle();
    int         idx;
    int         cnt;
    logic [3:0] one;
    logic [3:0] exp_an;
    idx = (k / DIV) % 4;
    cnt = k % DIV;
    one = 4'b0001 << idx;
    exp_an = (cnt < BLANK || mblk[idx]) ? 4'b1111 : ~one;
    chk("an", an, exp_an);
    chk("digit_code", digit_code, mdig[idx]);
    chk("frame_tick", {3'b0, frame_tick}, (k > 0 && k % 32 == 0) ? 4'd1 : 4'd0);
    chk("state", {2'b0, dbg_state}, (cnt < BLANK) ? 4'd1 : 4'd2);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      chk_cycle();
      tick();
      k++;
    end
  endtask

  task automatic chk_off(input string tag, input logic [3:0] exp_dc);
    chk({tag, "_an"}, an, 4'b1111);
    chk({tag, "_dc"}, digit_code, exp_dc);
    chk({tag, "_ft"}, {3'b0, frame_tick}, 4'd0);
    chk({tag, "_st"}, {2'b0, dbg_state}, 4'd0);
  endtask

  task automatic write(input logic [1:0] a, input logic [3:0] d, input logic b);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_blank = b;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fails = 0; k = 0;
    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0;
    wr_addr = 2'd0; wr_data = 4'h0; wr_blank = 1'b0;
    for (int i = 0; i < 4; i++) begin mdig[i] = 4'h0; mblk[i] = 1'b1; end

    // Reset values
    tick(); tick();
    chk_off("reset", 4'h0);

    // All digits blanked: anodes dark, tick every 32 cycles
    rst_n = 1'b1; en = 1'b1;
    tick(); k = 0;
    run(70);

    // Disable, then load digits 1..4 while OFF
    en = 1'b0;
    tick();
    chk_off("off", 4'h0);
    write(2'd0, 4'h1, 1'b0);
    write(2'd1, 4'h2, 1'b0);
    write(2'd2, 4'h3, 1'b0);
    write(2'd3, 4'h4, 1'b0);
    for (int i = 0; i < 4; i++) begin mdig[i] = 4'(i + 1); mblk[i] = 1'b0; end
    chk_off("off_wr", 4'h1);

    // Normal scan of four lit digits
    en = 1'b1;
    tick(); k = 0;
    run(64);

    // Blank digit 2 with data A
    en = 1'b0;
    tick();
    write(2'd2, 4'hA, 1'b1);
    mdig[2] = 4'hA; mblk[2] = 1'b1;
    chk_off("off_blk", 4'h1);
    en = 1'b1;
    tick(); k = 0;
    run(34);

    // Write the displayed digit during its ON phase
    chk_cycle();
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'hF; wr_blank = 1'b0;
    tick(); k++;
    wr_en = 1'b0; mdig[0] = 4'hF;
    run(4);

    // Write coinciding with the slot advance from digit 0 to digit 1
    chk_cycle();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h7; wr_blank = 1'b0;
    tick(); k++;
    wr_en = 1'b0; mdig[1] = 4'h7;
    run(35);

    // Drop en for one cycle in the ON phase of slot 1
    chk_cycle();
    en = 1'b0;
    tick();
    chk_off("en_drop", 4'hF);
    en = 1'b1;
    tick(); k = 0;
    run(40);

    // Reset mid-frame together with a write that must be discarded
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h5; wr_blank = 1'b0;
    tick();
    rst_n = 1'b1; wr_en = 1'b0; en = 1'b0;
    chk_off("rst_mid", 4'h0);
    for (int i = 0; i < 4; i++) begin mdig[i] = 4'h0; mblk[i] = 1'b1; end
    en = 1'b1;
    tick(); k = 0;
    run(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter DIV, default 50000, giving clock cycles per digit slot; legal range DIV >= BLANK+2.
REQ-002 The block SHALL have parameter BLANK, default 16, giving guard cycles at the start of each slot; legal range BLANK >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port en, input, 1 bit: scan enable.
REQ-006 The block SHALL have port wr_en, input, 1 bit: write strobe for the digit register file.
REQ-007 The block SHALL have port wr_addr, input, 2 bits: digit index to write (0 = rightmost).
REQ-008 The block SHALL have port wr_data, input, 4 bits: hex nibble to store.
REQ-009 The block SHALL have port wr_blank, input, 1 bit: blank flag stored with the nibble (1 = digit dark).
REQ-010 The block SHALL have port digit_code, output, 4 bits: nibble of the current digit, fed to the hex-to-7-segment decoder.
REQ-011 The block SHALL have port an, output, 4 bits: active-low anode enables, one per digit.
REQ-012 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse at the end of each full 4-digit frame.

Function
REQ-013 The block SHALL hold four 4-bit digit registers and four blank flags.
- With wr_en=1 at an edge: digit[wr_addr] <= wr_data and blank[wr_addr] <= wr_blank.
- Effect is visible on outputs the next cycle.
REQ-014 The block SHALL run a three-state FSM:
- OFF: en=0.
- GUARD: first BLANK cycles of a slot.
- ON: remaining DIV-BLANK cycles of a slot.
REQ-015 Transitions SHALL be:
- OFF->GUARD when en=1, with slot counter=0 and idx=0.
- GUARD->ON when slot counter = BLANK-1.
- ON->GUARD when slot counter = DIV-1; counter then goes to 0 and idx to idx+1 mod 4.
- Any state->OFF when en=0.
REQ-016 The slot counter SHALL count 0..DIV-1, increment every cycle outside OFF, and be forced to 0 in OFF.
REQ-017 The digit index idx SHALL be 2 bits and wrap from 3 to 0; in OFF it is forced to 0.
REQ-018 All outputs SHALL be registered.
- an = 4'b1111 in OFF, in GUARD, and in ON when blank[idx]=1.
- Otherwise an = ~(4'b0001 << idx): exactly one bit low.
REQ-019 digit_code SHALL equal digit[idx] registered, be updated in every state including GUARD, and reflect a write to the displayed digit one cycle after the write edge, with no anode change.
REQ-020 frame_tick SHALL be 1 for exactly the one cycle after the ON->GUARD transition that wraps idx from 3 to 0, and 0 at all other times, including in OFF.
REQ-021 If a write and a slot advance occur on the same edge, both SHALL take effect; the write is not lost and the advance is not delayed.
REQ-022 If en falls mid-slot, the block SHALL enter OFF on that edge, with an = 4'b1111 on the next cycle; the scan restarts at idx=0, GUARD, counter 0.
REQ-023 Writes SHALL be accepted in every state, including OFF.

Reset
REQ-024 When rst_n=0 at a rising clk edge, the block SHALL set:
- state = OFF, slot counter = 0, idx = 0;
- all digit registers = 4'h0, all blank flags = 1;
- an = 4'b1111, digit_code = 4'h0, frame_tick = 0.
REQ-025 Reset SHALL take priority over en and wr_en on the same edge; a write presented during reset is discarded.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no frame_tick.

Verification (DIV=8, BLANK=2)
REQ-027 Reset then en=1, no writes -> an stays 4'b1111 for all cycles (all digits blanked); frame_tick pulses every 32 cycles.
REQ-028 Write digits 0..3 = 1,2,3,4 with wr_blank=0, then en=1 -> per 8-cycle slot: 2 cycles an=1111, then 6 cycles an=1110/1101/1011/0111 in turn, with digit_code=1/2/3/4.
REQ-029 Write digit 2 with wr_data=4'hA, wr_blank=1 -> during slot 2, an=1111 throughout; the other slots are unchanged.
REQ-030 While digit 0 is ON, write 4'hF to addr 0 -> digit_code=F on the next cycle; an stays 1110; slot timing is unchanged.
REQ-031 Drop en in the ON phase of slot 1 for 1 cycle -> an=1111 the following cycle; the scan resumes at digit 0 GUARD; no frame_tick until 32 cycles later.
REQ-032 Assert rst_n=0 for 1 cycle together with wr_en (addr 1, data 5) mid-frame -> all registers are at reset values and digit 1 reads 0 and blanked.
